// File: rtl/mdu_pkg.sv
// Shared multiply/divide definitions: MDOp encodings (also used by controller and stall unit)
// and the pending-result record held while a long operation is in flight.
package mdu_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MTHI  = 4'd5;
    localparam logic [3:0] MD_MTLO  = 4'd6;
    localparam logic [3:0] MD_MFHI  = 4'd7;
    localparam logic [3:0] MD_MFLO  = 4'd8;

    typedef struct packed {
        logic        we;
        logic [31:0] hi;
        logic [31:0] lo;
    } md_result_t;

    function automatic logic is_long_op(input logic [3:0] op);
        return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
    endfunction

endpackage

// File: rtl/mdu_if.sv
// EX-stage MDU bus: issue side (Start/MDOp/operands) and result side (Busy/HI/LO/MDO).
interface mdu_if;
    logic        Start;
    logic [3:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDO;

    modport master (output Start, MDOp, A, B, input Busy, HI, LO, MDO);
    modport slave  (input Start, MDOp, A, B, output Busy, HI, LO, MDO);
endinterface

// File: rtl/mdu_timer.sv
// Loadable down-counter: Busy while nonzero, done marks the last Busy cycle.
module mdu_timer #(
    parameter int unsigned CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          busy,
    output logic          done
);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != '0);
    assign done = (cnt_q == CW'(1));

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit: computes the full result at issue, holds it pending for the
// configured latency, then commits it to HI/LO.
module mdu
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10
) (
    input  logic  clk,
    input  logic  reset,
    mdu_if.slave  bus
);

    localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int unsigned CW      = $clog2(MAX_LAT + 1);

    logic          issue, load, busy, done;
    logic [CW-1:0] load_val;
    logic [63:0]   prod_s, prod_u;
    logic signed [31:0] a_s, b_s, quot_s, rem_s;
    md_result_t    res_d, pend_q;
    logic [31:0]   hi_q, lo_q;

    assign issue    = bus.Start && !busy;
    assign load     = issue && is_long_op(bus.MDOp);
    assign load_val = (bus.MDOp inside {MD_MULT, MD_MULTU}) ? CW'(MULT_LAT) : CW'(DIV_LAT);

    // Sign-extended operands make the low 64 bits of an unsigned multiply the signed product.
    assign prod_s = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
    assign prod_u = {32'b0, bus.A} * {32'b0, bus.B};
    assign a_s    = bus.A;
    assign b_s    = bus.B;
    assign quot_s = a_s / b_s;
    assign rem_s  = a_s % b_s;

    always_comb begin
        res_d    = '0;
        res_d.we = 1'b1;
        case (bus.MDOp)
            MD_MULT:  {res_d.hi, res_d.lo} = prod_s;
            MD_MULTU: {res_d.hi, res_d.lo} = prod_u;
            MD_DIV: begin
                if (bus.B == '0) begin
                    res_d.we = 1'b0;
                end else if (bus.A == 32'h8000_0000 && bus.B == 32'hFFFF_FFFF) begin
                    res_d.lo = 32'h8000_0000;
                    res_d.hi = '0;
                end else begin
                    res_d.lo = quot_s;
                    res_d.hi = rem_s;
                end
            end
            MD_DIVU: begin
                if (bus.B == '0) begin
                    res_d.we = 1'b0;
                end else begin
                    res_d.lo = bus.A / bus.B;
                    res_d.hi = bus.A % bus.B;
                end
            end
            default: res_d.we = 1'b0;
        endcase
    end

    mdu_timer #(
        .CW (CW)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .busy     (busy),
        .done     (done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q   <= '0;
            lo_q   <= '0;
            pend_q <= '0;
        end else begin
            if (load) begin
                pend_q <= res_d;
            end
            // done implies busy, so a commit never coincides with an mthi/mtlo issue.
            if (done && pend_q.we) begin
                hi_q <= pend_q.hi;
                lo_q <= pend_q.lo;
            end
            if (issue && bus.MDOp == MD_MTHI) begin
                hi_q <= bus.A;
            end
            if (issue && bus.MDOp == MD_MTLO) begin
                lo_q <= bus.A;
            end
        end
    end

    assign bus.Busy = busy;
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;
    assign bus.MDO  = (bus.MDOp == MD_MFHI) ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu.sv
// Randomized self-checking bench for mdu against an arithmetic reference model.
module tb_mdu;
    import mdu_pkg::*;

    localparam int unsigned MULT_LAT = 5;
    localparam int unsigned DIV_LAT  = 10;

    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_err = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mdu_if bus ();

    mdu #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h want %08h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic, quotient truncates toward zero.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            MD_MULT:  begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; end
            MD_MULTU: begin p = {32'b0, a} * {32'b0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
            MD_DIV: if (b != 0) begin
                q = sa / sb;
                r = sa - q * sb;
                m_lo = q[31:0];
                m_hi = r[31:0];
            end
            MD_DIVU: if (b != 0) begin
                m_lo = a / b;
                m_hi = a - (a / b) * b;
            end
            MD_MTHI: m_hi = a;
            MD_MTLO: m_lo = a;
            default: ;
        endcase
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] corners [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.Start = 1'b1;
        bus.MDOp  = op;
        bus.A     = a;
        bus.B     = b;
    endtask

    // Called just after a negedge; returns on the first negedge with Busy low.
    task automatic run_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int cnt;
        logic [31:0] old_lo;
        old_lo = m_lo;
        drive(op, a, b);
        @(negedge clk);
        bus.Start = 1'b0;
        bus.A     = $urandom;
        bus.B     = $urandom;
        bus.MDOp  = MD_MFLO;
        #1 chk("mdo_old_while_busy", bus.MDO, old_lo);
        cnt = 0;
        while (bus.Busy && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        model(op, a, b);
        chk("busy_len", 32'(cnt), (op inside {MD_MULT, MD_MULTU}) ? MULT_LAT : DIV_LAT);
        chk("hi", bus.HI, m_hi);
        chk("lo", bus.LO, m_lo);
    endtask

    task automatic run_mt(input logic [3:0] op, input logic [31:0] a);
        drive(op, a, $urandom);
        @(negedge clk);
        bus.Start = 1'b0;
        model(op, a, 32'h0);
        chk("mt_busy", 32'(bus.Busy), 32'h0);
        chk("mt_hi", bus.HI, m_hi);
        chk("mt_lo", bus.LO, m_lo);
        bus.MDOp = MD_MFHI;
        #1 chk("mdo_mfhi", bus.MDO, m_hi);
        bus.MDOp = MD_MFLO;
        #1 chk("mdo_mflo", bus.MDO, m_lo);
    endtask

    task automatic run_nop(input logic [3:0] op);
        drive(op, $urandom, $urandom);
        @(negedge clk);
        bus.Start = 1'b0;
        chk("nop_busy", 32'(bus.Busy), 32'h0);
        chk("nop_hi", bus.HI, m_hi);
        chk("nop_lo", bus.LO, m_lo);
    endtask

    initial begin
        int cnt;
        logic [3:0] op;
        bus.Start = 1'b0;
        bus.MDOp  = MD_NONE;
        bus.A     = '0;
        bus.B     = '0;
        reset     = 1'b0;
        #12;
        chk("rst_busy", 32'(bus.Busy), 32'h0);
        chk("rst_hi", bus.HI, 32'h0);
        chk("rst_lo", bus.LO, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        run_md(MD_MULT, 32'hFFFF_FFFE, 32'h3);
        run_md(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_md(MD_DIV, 32'hFFFF_FFF9, 32'h2);
        run_md(MD_DIVU, 32'h7, 32'h0);
        run_md(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_mt(MD_MTHI, 32'h1234_5678);

        // Reset during the fourth Busy cycle of a divide.
        drive(MD_DIV, 32'h64, 32'h7);
        @(negedge clk);
        bus.Start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", 32'(bus.Busy), 32'h1);
        #2 reset = 1'b0;
        #1;
        m_hi = '0;
        m_lo = '0;
        chk("async_busy", 32'(bus.Busy), 32'h0);
        chk("async_hi", bus.HI, 32'h0);
        chk("async_lo", bus.LO, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        repeat (15) @(negedge clk);
        chk("no_late_hi", bus.HI, 32'h0);
        chk("no_late_lo", bus.LO, 32'h0);

        // mtlo while a mult is in flight must be dropped.
        drive(MD_MULT, 32'h1234, 32'h100);
        @(negedge clk);
        bus.Start = 1'b0;
        @(negedge clk);
        drive(MD_MTLO, 32'hDEAD_BEEF, 32'h0);
        @(negedge clk);
        bus.Start = 1'b0;
        cnt = 2;
        while (bus.Busy && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        model(MD_MULT, 32'h1234, 32'h100);
        chk("ign_busy_len", 32'(cnt), MULT_LAT);
        chk("ign_lo", bus.LO, m_lo);
        chk("ign_hi", bus.HI, m_hi);
        run_mt(MD_MTLO, 32'hCAFE_BABE);

        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            if (is_long_op(op)) run_md(op, pick(), pick());
            else if (op == MD_MTHI || op == MD_MTLO) run_mt(op, pick());
            else run_nop(op);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
